// File: rtl/core_pkg.sv
// Shared core definitions: datapath widths and the ID/EX control payload.
package core_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int REG_ADDR_W = 5;

  // Destination/control part of the ID/EX payload. It is independent of the
  // datapath width, so it stays valid when DATA_WIDTH is overridden.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic                  rd_wen;
    logic                  is_load;
  } id_ex_ctrl_t;

  localparam id_ex_ctrl_t ID_EX_CTRL_RESET = '{rd: '0, rd_wen: 1'b0, is_load: 1'b0};

endpackage : core_pkg

// File: rtl/operand_fwd_mux.sv
// Source-operand bypass select: x0 reads zero, then EX/MEM result, then the
// writeback value, and only then the register file read data.
module operand_fwd_mux import core_pkg::*; #(
  parameter int W = DATA_WIDTH
) (
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic [W-1:0]          rf_data,
  input  logic                  mem_valid,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [W-1:0]          mem_data,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [W-1:0]          wb_data,
  output logic [W-1:0]          operand
);

  // Priority select; the youngest producer (MEM) wins over WB.
  always_comb begin
    operand = rf_data;
    if (rs == '0) begin
      operand = '0;
    end else if (mem_valid && (mem_rd == rs)) begin
      operand = mem_data;
    end else if (wb_valid && (wb_rd == rs)) begin
      operand = wb_data;
    end else begin
      operand = rf_data;
    end
  end

endmodule : operand_fwd_mux

// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register with operand bypass, load-use stall,
// downstream backpressure and flush.
module id_ex_stage import core_pkg::*; #(
  parameter int DATA_WIDTH = core_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid_i,
  output logic                  id_ready_o,
  input  logic [DATA_WIDTH-1:0] id_pc_i,
  input  logic [DATA_WIDTH-1:0] id_imm_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic [REG_ADDR_W-1:0] id_rd_i,
  input  logic                  id_uses_rs1_i,
  input  logic                  id_uses_rs2_i,
  input  logic                  id_rd_wen_i,
  input  logic                  id_is_load_i,
  output logic [REG_ADDR_W-1:0] rf_rs1_o,
  output logic [REG_ADDR_W-1:0] rf_rs2_o,
  input  logic [DATA_WIDTH-1:0] rf_rs1_data_i,
  input  logic [DATA_WIDTH-1:0] rf_rs2_data_i,
  input  logic                  mem_fwd_valid_i,
  input  logic [REG_ADDR_W-1:0] mem_fwd_rd_i,
  input  logic [DATA_WIDTH-1:0] mem_fwd_data_i,
  input  logic                  wb_fwd_valid_i,
  input  logic [REG_ADDR_W-1:0] wb_fwd_rd_i,
  input  logic [DATA_WIDTH-1:0] wb_fwd_data_i,
  input  logic                  flush_i,
  output logic                  ex_valid_o,
  input  logic                  ex_ready_i,
  output logic [DATA_WIDTH-1:0] ex_pc_o,
  output logic [DATA_WIDTH-1:0] ex_imm_o,
  output logic [DATA_WIDTH-1:0] ex_rs1_data_o,
  output logic [DATA_WIDTH-1:0] ex_rs2_data_o,
  output logic [REG_ADDR_W-1:0] ex_rd_o,
  output logic                  ex_rd_wen_o,
  output logic                  ex_is_load_o
);

  logic                  ex_valid_r;
  logic [DATA_WIDTH-1:0] ex_pc_r;
  logic [DATA_WIDTH-1:0] ex_imm_r;
  logic [DATA_WIDTH-1:0] ex_rs1_data_r;
  logic [DATA_WIDTH-1:0] ex_rs2_data_r;
  id_ex_ctrl_t           ex_ctrl_r;

  logic                  load_use_s;
  logic                  accept_s;
  logic                  id_ready_s;
  logic [DATA_WIDTH-1:0] rs1_fwd_s;
  logic [DATA_WIDTH-1:0] rs2_fwd_s;

  assign rf_rs1_o = id_rs1_i;
  assign rf_rs2_o = id_rs2_i;

  operand_fwd_mux #(.W(DATA_WIDTH)) u_rs1_mux (
    .rs        (id_rs1_i),
    .rf_data   (rf_rs1_data_i),
    .mem_valid (mem_fwd_valid_i),
    .mem_rd    (mem_fwd_rd_i),
    .mem_data  (mem_fwd_data_i),
    .wb_valid  (wb_fwd_valid_i),
    .wb_rd     (wb_fwd_rd_i),
    .wb_data   (wb_fwd_data_i),
    .operand   (rs1_fwd_s)
  );

  operand_fwd_mux #(.W(DATA_WIDTH)) u_rs2_mux (
    .rs        (id_rs2_i),
    .rf_data   (rf_rs2_data_i),
    .mem_valid (mem_fwd_valid_i),
    .mem_rd    (mem_fwd_rd_i),
    .mem_data  (mem_fwd_data_i),
    .wb_valid  (wb_fwd_valid_i),
    .wb_rd     (wb_fwd_rd_i),
    .wb_data   (wb_fwd_data_i),
    .operand   (rs2_fwd_s)
  );

  // Hazard detect and upstream handshake: a held load whose result the
  // incoming instruction needs cannot be bypassed yet, so decode must wait.
  always_comb begin
    load_use_s = 1'b0;
    if (ex_valid_r && ex_ctrl_r.is_load && ex_ctrl_r.rd_wen && (ex_ctrl_r.rd != '0)) begin
      load_use_s = (id_uses_rs1_i && (id_rs1_i == ex_ctrl_r.rd)) ||
                   (id_uses_rs2_i && (id_rs2_i == ex_ctrl_r.rd));
    end else begin
      load_use_s = 1'b0;
    end
    id_ready_s = (!ex_valid_r || ex_ready_i) && !load_use_s && !flush_i;
    accept_s   = id_valid_i && id_ready_s;
  end

  assign id_ready_o = id_ready_s;

  // Valid bit: flush kills, accept loads, a consumed entry without refill
  // becomes a bubble, otherwise the entry is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_r <= 1'b0;
    end else if (flush_i) begin
      ex_valid_r <= 1'b0;
    end else if (accept_s) begin
      ex_valid_r <= 1'b1;
    end else if (ex_ready_i) begin
      ex_valid_r <= 1'b0;
    end else begin
      ex_valid_r <= ex_valid_r;
    end
  end

  // Payload capture only on accept so held outputs never change under stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_pc_r       <= '0;
      ex_imm_r      <= '0;
      ex_rs1_data_r <= '0;
      ex_rs2_data_r <= '0;
      ex_ctrl_r     <= ID_EX_CTRL_RESET;
    end else if (accept_s) begin
      ex_pc_r        <= id_pc_i;
      ex_imm_r       <= id_imm_i;
      ex_rs1_data_r  <= rs1_fwd_s;
      ex_rs2_data_r  <= rs2_fwd_s;
      ex_ctrl_r.rd      <= id_rd_i;
      ex_ctrl_r.rd_wen  <= id_rd_wen_i;
      ex_ctrl_r.is_load <= id_is_load_i;
    end else begin
      ex_pc_r       <= ex_pc_r;
      ex_imm_r      <= ex_imm_r;
      ex_rs1_data_r <= ex_rs1_data_r;
      ex_rs2_data_r <= ex_rs2_data_r;
      ex_ctrl_r     <= ex_ctrl_r;
    end
  end

  assign ex_valid_o    = ex_valid_r;
  assign ex_pc_o       = ex_pc_r;
  assign ex_imm_o      = ex_imm_r;
  assign ex_rs1_data_o = ex_rs1_data_r;
  assign ex_rs2_data_o = ex_rs2_data_r;
  assign ex_rd_o       = ex_ctrl_r.rd;
  assign ex_rd_wen_o   = ex_ctrl_r.rd_wen;
  assign ex_is_load_o  = ex_ctrl_r.is_load;

endmodule : id_ex_stage

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: forwarding vector table, hand-written
// hazard/backpressure/flush/reset sequences, then random traffic against a
// queue-based model of a one-entry stage.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, id_ready;
  logic [31:0] id_pc, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_uses_rs1, id_uses_rs2, id_rd_wen, id_is_load;
  logic [4:0]  rf_rs1, rf_rs2;
  logic [31:0] rf_rs1_data, rf_rs2_data;
  logic        mem_fwd_valid, wb_fwd_valid;
  logic [4:0]  mem_fwd_rd, wb_fwd_rd;
  logic [31:0] mem_fwd_data, wb_fwd_data;
  logic        flush, ex_valid, ex_ready;
  logic [31:0] ex_pc, ex_imm, ex_rs1_data, ex_rs2_data;
  logic [4:0]  ex_rd;
  logic        ex_rd_wen, ex_is_load;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid_i(id_valid), .id_ready_o(id_ready),
    .id_pc_i(id_pc), .id_imm_i(id_imm),
    .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_rd_i(id_rd),
    .id_uses_rs1_i(id_uses_rs1), .id_uses_rs2_i(id_uses_rs2),
    .id_rd_wen_i(id_rd_wen), .id_is_load_i(id_is_load),
    .rf_rs1_o(rf_rs1), .rf_rs2_o(rf_rs2),
    .rf_rs1_data_i(rf_rs1_data), .rf_rs2_data_i(rf_rs2_data),
    .mem_fwd_valid_i(mem_fwd_valid), .mem_fwd_rd_i(mem_fwd_rd), .mem_fwd_data_i(mem_fwd_data),
    .wb_fwd_valid_i(wb_fwd_valid), .wb_fwd_rd_i(wb_fwd_rd), .wb_fwd_data_i(wb_fwd_data),
    .flush_i(flush),
    .ex_valid_o(ex_valid), .ex_ready_i(ex_ready),
    .ex_pc_o(ex_pc), .ex_imm_o(ex_imm),
    .ex_rs1_data_o(ex_rs1_data), .ex_rs2_data_o(ex_rs2_data),
    .ex_rd_o(ex_rd), .ex_rd_wen_o(ex_rd_wen), .ex_is_load_o(ex_is_load)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle();
    id_valid = 1'b0; id_pc = 32'd0; id_imm = 32'd0;
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_rd = 5'd0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; id_rd_wen = 1'b0; id_is_load = 1'b0;
    rf_rs1_data = 32'd0; rf_rs2_data = 32'd0;
    mem_fwd_valid = 1'b0; mem_fwd_rd = 5'd0; mem_fwd_data = 32'd0;
    wb_fwd_valid = 1'b0; wb_fwd_rd = 5'd0; wb_fwd_data = 32'd0;
    flush = 1'b0; ex_ready = 1'b1;
  endtask

  // One clock: rising edge happens, sampling resumes on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, ex_valid, 32'd0);
    check({tag, "_pc"}, ex_pc, 32'd0);
    check({tag, "_imm"}, ex_imm, 32'd0);
    check({tag, "_a"}, ex_rs1_data, 32'd0);
    check({tag, "_b"}, ex_rs2_data, 32'd0);
    check({tag, "_ctl"}, {ex_rd, ex_rd_wen, ex_is_load}, 32'd0);
  endtask

  // Operand rule written straight from the forwarding description.
  function automatic logic [31:0] pick(input logic [4:0] idx, input logic [31:0] rf,
                                       input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                                       input logic wv, input logic [4:0] wrd, input logic [31:0] wd);
    if (idx == 5'd0) return 32'd0;
    if (mv && mrd == idx) return md;
    if (wv && wrd == idx) return wd;
    return rf;
  endfunction

  typedef struct {
    logic [4:0] rs1, rs2; logic [31:0] rf1, rf2;
    logic mv; logic [4:0] mrd; logic [31:0] md;
    logic wv; logic [4:0] wrd; logic [31:0] wd;
    logic [31:0] exp1, exp2;
  } vec_t;

  typedef struct {
    logic [31:0] pc, imm, a, b; logic [4:0] rd; logic wen, ld;
  } rec_t;

  vec_t vecs[6];
  rec_t q[$];
  rec_t last, r;
  logic held, lu, exp_rdy;

  initial begin
    vecs[0] = '{5'd5, 5'd6, 32'h0, 32'h66, 1'b1, 5'd5, 32'h11, 1'b0, 5'd0, 32'h0, 32'h11, 32'h66};
    vecs[1] = '{5'd7, 5'd7, 32'hCC, 32'hCC, 1'b1, 5'd7, 32'hAA, 1'b1, 5'd7, 32'hBB, 32'hAA, 32'hAA};
    vecs[2] = '{5'd7, 5'd7, 32'hCC, 32'hCC, 1'b0, 5'd7, 32'hAA, 1'b1, 5'd7, 32'hBB, 32'hBB, 32'hBB};
    vecs[3] = '{5'd0, 5'd0, 32'h1234, 32'h5678, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 32'hFFFF_FFFF, 32'h0, 32'h0};
    vecs[4] = '{5'd9, 5'd10, 32'h9, 32'hA, 1'b1, 5'd10, 32'h10, 1'b1, 5'd9, 32'h99, 32'h99, 32'h10};
    vecs[5] = '{5'd1, 5'd2, 32'h1, 32'h2, 1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44, 32'h1, 32'h2};

    idle();
    rst_n = 1'b0;
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_ready", id_ready, 32'd1);

    // Forwarding table: each vector accepted into an empty stage.
    for (int i = 0; i < 6; i++) begin
      idle();
      id_valid = 1'b1; id_pc = 32'h1000 + i;
      id_rs1 = vecs[i].rs1; id_rs2 = vecs[i].rs2; id_uses_rs1 = 1'b1; id_uses_rs2 = 1'b1;
      rf_rs1_data = vecs[i].rf1; rf_rs2_data = vecs[i].rf2;
      mem_fwd_valid = vecs[i].mv; mem_fwd_rd = vecs[i].mrd; mem_fwd_data = vecs[i].md;
      wb_fwd_valid = vecs[i].wv; wb_fwd_rd = vecs[i].wrd; wb_fwd_data = vecs[i].wd;
      #1;
      check($sformatf("vec%0d_rf_addr", i), {rf_rs1, rf_rs2}, {22'd0, vecs[i].rs1, vecs[i].rs2});
      step();
      check($sformatf("vec%0d_valid", i), ex_valid, 32'd1);
      check($sformatf("vec%0d_pc", i), ex_pc, 32'h1000 + i);
      check($sformatf("vec%0d_rs1", i), ex_rs1_data, vecs[i].exp1);
      check($sformatf("vec%0d_rs2", i), ex_rs2_data, vecs[i].exp2);
    end
    idle();
    step();
    check("drain_bubble", ex_valid, 32'd0);

    // Load-use: held lw x3, incoming add reads x3 through rs2.
    idle();
    id_valid = 1'b1; id_pc = 32'h200; id_rd = 5'd3; id_rd_wen = 1'b1; id_is_load = 1'b1;
    step();
    id_is_load = 1'b0; id_pc = 32'h204; id_rd = 5'd8; id_rs2 = 5'd3; id_uses_rs2 = 1'b1;
    #1;
    check("lu_ready_low", id_ready, 32'd0);
    step();
    check("lu_bubble", ex_valid, 32'd0);
    check("lu_ready_back", id_ready, 32'd1);
    step();
    check("lu_add_valid", ex_valid, 32'd1);
    check("lu_add_pc", ex_pc, 32'h204);
    check("lu_add_rd", ex_rd, 32'd8);

    // Backpressure: three stalled cycles, then the waiting instruction lands.
    idle();
    id_valid = 1'b1; id_pc = 32'h300; id_imm = 32'h33; id_rd = 5'd4; id_rd_wen = 1'b1;
    step();
    ex_ready = 1'b0; id_pc = 32'h400; id_imm = 32'h44; id_rd = 5'd6;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("bp%0d_ready", k), id_ready, 32'd0);
      step();
      check($sformatf("bp%0d_valid", k), ex_valid, 32'd1);
      check($sformatf("bp%0d_pc", k), ex_pc, 32'h300);
      check($sformatf("bp%0d_imm", k), ex_imm, 32'h33);
      check($sformatf("bp%0d_rd", k), ex_rd, 32'd4);
    end
    ex_ready = 1'b1;
    step();
    check("bp_next_pc", ex_pc, 32'h400);
    check("bp_next_valid", ex_valid, 32'd1);

    // Flush beats both stall and a pending accept.
    ex_ready = 1'b0; id_pc = 32'h500; flush = 1'b1;
    #1;
    check("flush_ready", id_ready, 32'd0);
    step();
    check("flush_valid", ex_valid, 32'd0);
    check("flush_pc_kept", ex_pc, 32'h400);

    // Reset asserted mid-stall clears outputs without waiting for a clock.
    idle();
    id_valid = 1'b1; id_pc = 32'h600; id_imm = 32'h66; id_rs1 = 5'd1; id_uses_rs1 = 1'b1;
    rf_rs1_data = 32'hDEAD; id_rd = 5'd9; id_rd_wen = 1'b1; id_is_load = 1'b1;
    step();
    ex_ready = 1'b0;
    step();
    check("stall_before_rst", ex_valid, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_mid");
    @(negedge clk);
    idle();
    id_valid = 1'b1; id_pc = 32'h700;
    rst_n = 1'b1;
    step();
    check("post_rst_accept_valid", ex_valid, 32'd1);
    check("post_rst_accept_pc", ex_pc, 32'h700);
    idle();
    flush = 1'b1;
    step();
    idle();

    // Random traffic against a queue model of the one-entry stage.
    q.delete();
    last = '{32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0};
    last.pc = 32'h700;
    for (int c = 0; c < 400; c++) begin
      id_valid = ($urandom_range(0, 3) != 0);
      id_pc = $urandom; id_imm = $urandom;
      id_rs1 = 5'($urandom_range(0, 7)); id_rs2 = 5'($urandom_range(0, 7));
      id_rd = 5'($urandom_range(0, 7));
      id_uses_rs1 = 1'($urandom_range(0, 1)); id_uses_rs2 = 1'($urandom_range(0, 1));
      id_rd_wen = 1'($urandom_range(0, 1)); id_is_load = 1'($urandom_range(0, 1));
      rf_rs1_data = $urandom; rf_rs2_data = $urandom;
      mem_fwd_valid = 1'($urandom_range(0, 1)); mem_fwd_rd = 5'($urandom_range(0, 7));
      mem_fwd_data = $urandom;
      wb_fwd_valid = 1'($urandom_range(0, 1)); wb_fwd_rd = 5'($urandom_range(0, 7));
      wb_fwd_data = $urandom;
      flush = ($urandom_range(0, 15) == 0);
      ex_ready = ($urandom_range(0, 2) != 0);
      #1;
      held = (q.size() != 0);
      lu = 1'b0;
      if (held) lu = q[0].ld && q[0].wen && (q[0].rd != 5'd0) &&
                     ((id_uses_rs1 && id_rs1 == q[0].rd) || (id_uses_rs2 && id_rs2 == q[0].rd));
      exp_rdy = (!held || ex_ready) && !lu && !flush;
      check("rand_ready", id_ready, exp_rdy);
      if (flush) begin
        q.delete();
      end else if (id_valid && exp_rdy) begin
        r.pc = id_pc; r.imm = id_imm; r.rd = id_rd; r.wen = id_rd_wen; r.ld = id_is_load;
        r.a = pick(id_rs1, rf_rs1_data, mem_fwd_valid, mem_fwd_rd, mem_fwd_data,
                   wb_fwd_valid, wb_fwd_rd, wb_fwd_data);
        r.b = pick(id_rs2, rf_rs2_data, mem_fwd_valid, mem_fwd_rd, mem_fwd_data,
                   wb_fwd_valid, wb_fwd_rd, wb_fwd_data);
        q.delete();
        q.push_back(r);
        last = r;
      end else if (ex_ready) begin
        q.delete();
      end
      step();
      check("rand_valid", ex_valid, (q.size() != 0) ? 32'd1 : 32'd0);
      check("rand_pc", ex_pc, last.pc);
      check("rand_imm", ex_imm, last.imm);
      check("rand_rs1", ex_rs1_data, last.a);
      check("rand_rs2", ex_rs2_data, last.b);
      check("rand_ctl", {ex_rd, ex_rd_wen, ex_is_load}, {25'd0, last.rd, last.wen, last.ld});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_id_ex_stage
